pad_stream_ctrl: RTL and testbench
==================================

Name: pad_stream_ctrl

Overview:
Sequencer that streams one SIZE x SIZE feature map out of a synchronous read memory and emits the zero-padded (SIZE+2*PAD) x (SIZE+2*PAD) map as a raster-order valid/ready stream. It replaces whole-array padding registers with address generation plus border-zero insertion, and feeds the convolution window stage. Frames are started by the layer controller with a start pulse and base address.

Parameters:
DATA_W, 32, pixel width in bits
SIZE, 5, input map side length (>=1)
PAD, 1, zero border width on every side (>=0)
ADDR_W, 16, feature-memory address width

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin a frame; sampled only in IDLE
base_addr  input  ADDR_W  address of pixel (0,0); captured when start is accepted
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse after the last output handshake
rd_en  output  1  memory read strobe
rd_addr  output  ADDR_W  memory read address
rd_data  input  DATA_W  read data, valid exactly 1 cycle after rd_en
out_valid  output  1  output element valid
out_ready  input  1  downstream accept
out_data  output  DATA_W  padded pixel
out_row_last  output  1  marks the last column of each output row
out_last  output  1  marks the final element of the frame

Behaviour:
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, out_valid=0, out_data=0, out_row_last=0, out_last=0. All counters are zero, the buffer is empty, and the state is IDLE.
- OUT = SIZE+2*PAD. Output index (r,c) runs over r,c in 0..OUT-1 in raster order.
- Interior test: r and c are both in [PAD, PAD+SIZE-1]. An interior element issues rd_en with rd_addr = base + (r-PAD)*SIZE + (c-PAD), truncated to ADDR_W. A border element issues no read and carries 0.
- Border zeros pass through the same 1-cycle issue stage as reads, so element order is preserved without reordering logic.
- Output side: a 2-entry buffer. One element is issued per cycle only when (buffer occupancy + in-flight element - pop this cycle) < 2. This gives no overflow, and 1 element/cycle throughput while out_ready=1.
- A handshake occurs when out_valid && out_ready. out_data, out_row_last and out_last stay stable while out_valid=1 and out_ready=0.
- out_row_last=1 when c==OUT-1. out_last=1 when r==OUT-1 and c==OUT-1.
- FSM:
  - IDLE: if start, capture base_addr and clear r,c, then go to RUN.
  - RUN: issue elements, advancing c and wrapping to r+1. After the final element is issued, go to DRAIN.
  - DRAIN: no issue. When the handshake with out_last occurs, go to DONE.
  - DONE: done=1 for one cycle, busy=0, then go to IDLE.
- busy=1 in RUN and DRAIN.
- Latency: with start high in cycle 0 and out_ready=1, the first out_valid is in cycle 2. The frame takes OUT*OUT+2 cycles from start to the last handshake, and done follows on the next cycle.
- start while busy or in DONE is ignored. Exactly one read is issued per interior pixel, totalling SIZE*SIZE reads per frame.
- PAD=0 is a pure passthrough stream of SIZE*SIZE reads.
- Reset mid-frame returns the block to IDLE on the next edge. In-flight read data is discarded, the buffer is flushed, and no done pulse is generated.
- out_ready held low does not stop progress until the buffer and the in-flight slot are full. After that, rd_en stays 0 until space frees.

Decomposition:
- Shared package cnn_pkg:
  - data_t (logic [DATA_W-1:0], 32 by default)
  - pad_state_e enum {IDLE, RUN, DRAIN, DONE}
  - function out_dim(size, pad) returning size+2*pad
- Sub-module pad_skid_buf: 2-entry valid/ready buffer holding {data, row_last, last}, with push/pop/occupancy outputs.
- The top level holds the FSM, row/column counters, address generation and the issue-credit logic.

Test Plan:
- SIZE=3, PAD=1, base=0x10, memory[a]=a, out_ready=1.
  - Output is 25 elements, first out_valid at cycle 2.
  - Row 0 is all 0. Row 1 is 0,0x10,0x11,0x12,0. Row 4 is all 0.
  - out_row_last is high on indices 4,9,14,19,24. out_last only on element 24. done one cycle later.
  - Exactly 9 rd_en.
- Same frame with out_ready toggling 1,0,0,1 repeatedly:
  - Identical 25-element sequence, no drops or duplicates.
  - out_data stable while stalled. rd_en never issued with 2 elements pending.
- PAD=0, SIZE=2, base=0x100:
  - Stream is 0x100,0x101,0x102,0x103. out_last on 0x103.
  - 4 reads, no zero insertion.
- start pulsed again mid-frame and during the DONE cycle:
  - Ignored. Only one done pulse. Next start in IDLE runs a fresh frame.
- reset asserted at the 7th element with out_ready=0:
  - Next cycle has all outputs at reset values, no done.
  - A subsequent start produces a complete correct frame from (0,0).
- base_addr=0xFFFE, SIZE=2, PAD=0, ADDR_W=16:
  - Addresses are 0xFFFE,0xFFFF,0x0000,0x0001 (wrap-around).

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN feature-map streaming blocks.
package cnn_pkg;

  localparam int DATA_W_DEF = 32;

  typedef logic [DATA_W_DEF-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pad_state_e;

  // Side length of a map after adding a border of 'pad' on every side.
  function automatic int out_dim(input int size, input int pad);
    return size + 2 * pad;
  endfunction

endpackage

// File: rtl/pad_skid_buf.sv
// Two-entry fall-through buffer for {data, row_last, last} elements.
// When empty, a pushed element is visible on the output in the same cycle;
// if it is not popped it is stored, so the output stays stable while stalled.
module pad_skid_buf #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;

  logic w_empty;
  logic w_wr;
  logic w_rd;

  assign w_empty = (r_count == 2'd0);
  // An element pushed into an empty buffer and popped in the same cycle bypasses storage.
  assign w_wr    = i_push && !(w_empty && i_pop);
  assign w_rd    = i_pop && !w_empty;
  assign o_valid = !w_empty || i_push;
  assign o_data  = w_empty ? i_data : r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_wr) r_wr_ptr <= ~r_wr_ptr;
      if (w_rd) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + 2'(w_wr) - 2'(w_rd);
    end
  end

  // Storage array; contents are meaningless while the count says empty.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/pad_stream_ctrl.sv
// Streams a SIZE x SIZE map from a 1-cycle read memory as a zero-padded
// (SIZE+2*PAD)^2 raster stream. Border zeros travel through the same issue
// stage as reads so order is preserved.
//
// Handshake: an output element transfers on a rising edge where
// out_valid && out_ready; while out_valid=1 and out_ready=0 the payload
// (out_data, out_row_last, out_last) is held unchanged.
module pad_stream_ctrl
  import cnn_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SIZE   = 5,
  parameter int PAD    = 1,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_row_last,
  output logic              out_last,
  output logic [1:0]        dbg_state
);

  localparam int OUT   = out_dim(SIZE, PAD);
  localparam int CNT_W = $clog2(OUT + 1);
  localparam int EW    = DATA_W + 2;
  localparam logic [CNT_W-1:0] PAD_C  = CNT_W'(PAD);
  localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(SIZE);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(OUT - 1);

  pad_state_e        r_state, w_next_state;
  logic [CNT_W-1:0]  r_row, r_col;
  logic [ADDR_W-1:0] r_base;
  logic              r_fl_valid, r_fl_int, r_fl_row_last, r_fl_last;

  logic [CNT_W-1:0]  w_row_off, w_col_off;
  logic [ADDR_W-1:0] w_offs;
  logic              w_interior, w_row_last_el, w_last_el;
  logic              w_issue, w_credit, w_pop;
  logic              w_buf_valid;
  logic [EW-1:0]     w_buf_data;
  logic [1:0]        w_buf_count;
  logic [DATA_W-1:0] w_fl_data;

  // Offsets into the interior; rows/cols above the border wrap to large
  // unsigned values, so a single "< SIZE" test covers both edges.
  assign w_row_off     = r_row - PAD_C;
  assign w_col_off     = r_col - PAD_C;
  assign w_interior    = (w_row_off < SIZE_C) && (w_col_off < SIZE_C);
  assign w_offs        = ADDR_W'(w_row_off) * ADDR_W'(SIZE) + ADDR_W'(w_col_off);
  assign w_row_last_el = (r_col == LAST_C);
  assign w_last_el     = w_row_last_el && (r_row == LAST_C);

  // Issue only if the buffer plus the in-flight slot still has room after this cycle's pop.
  assign w_pop    = w_buf_valid && out_ready;
  assign w_credit = ({1'b0, w_buf_count} + {2'b00, r_fl_valid}) < (3'd2 + {2'b00, w_pop});
  assign w_issue  = (r_state == RUN) && w_credit;

  assign rd_en   = w_issue && w_interior;
  assign rd_addr = rd_en ? (r_base + w_offs) : '0;

  assign w_fl_data = r_fl_int ? rd_data : '0;

  pad_skid_buf #(.W(EW)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_fl_valid),
    .i_data  ({w_fl_data, r_fl_row_last, r_fl_last}),
    .i_pop   (w_pop),
    .o_valid (w_buf_valid),
    .o_data  (w_buf_data),
    .o_count (w_buf_count)
  );

  assign out_valid = w_buf_valid;
  assign {out_data, out_row_last, out_last} = w_buf_valid ? w_buf_data : '0;
  assign busy      = (r_state == RUN) || (r_state == DRAIN);
  assign done      = (r_state == DONE);
  assign dbg_state = r_state;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = RUN;
      RUN:     if (w_issue && w_last_el) w_next_state = DRAIN;
      DRAIN:   if (w_pop && w_buf_data[0]) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Base capture and raster row/column counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_base <= '0;
      r_row  <= '0;
      r_col  <= '0;
    end else if (r_state == IDLE && start) begin
      r_base <= base_addr;
      r_row  <= '0;
      r_col  <= '0;
    end else if (w_issue) begin
      if (w_row_last_el) begin
        r_col <= '0;
        r_row <= r_row + CNT_W'(1);
      end else begin
        r_col <= r_col + CNT_W'(1);
      end
    end
  end

  // In-flight slot: tags the element whose read data (or zero) arrives next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fl_valid    <= 1'b0;
      r_fl_int      <= 1'b0;
      r_fl_row_last <= 1'b0;
      r_fl_last     <= 1'b0;
    end else begin
      r_fl_valid    <= w_issue;
      r_fl_int      <= rd_en;
      r_fl_row_last <= w_issue && w_row_last_el;
      r_fl_last     <= w_issue && w_last_el;
    end
  end

endmodule

// File: tb/tb_pad_stream_ctrl.sv
// Bench for pad_stream_ctrl: instance A (SIZE=3, PAD=1) and instance B
// (SIZE=2, PAD=0), each fed by a memory returning memory[a]=a.
module tb_pad_stream_ctrl;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SA = 3;
  localparam int PA = 1;
  localparam int SB = 2;
  localparam int PB = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, start_a, busy_a, done_a, rd_en_a, out_valid_a, out_ready_a, orl_a, ol_a;
  logic [AW-1:0] base_a, rd_addr_a;
  logic [DW-1:0] rd_data_a, out_data_a;
  logic [1:0]    st_a;
  logic          rst_b, start_b, busy_b, done_b, rd_en_b, out_valid_b, out_ready_b, orl_b, ol_b;
  logic [AW-1:0] base_b, rd_addr_b;
  logic [DW-1:0] rd_data_b, out_data_b;
  logic [1:0]    st_b;

  pad_stream_ctrl #(.DATA_W(DW), .SIZE(SA), .PAD(PA), .ADDR_W(AW)) u_dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .base_addr(base_a), .busy(busy_a),
    .done(done_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .out_row_last(orl_a), .out_last(ol_a), .dbg_state(st_a)
  );

  pad_stream_ctrl #(.DATA_W(DW), .SIZE(SB), .PAD(PB), .ADDR_W(AW)) u_dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .base_addr(base_b), .busy(busy_b),
    .done(done_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_row_last(orl_b), .out_last(ol_b), .dbg_state(st_b)
  );

  // Synchronous memories: data one cycle after rd_en, junk otherwise.
  always @(posedge clk) rd_data_a <= rd_en_a ? DW'(rd_addr_a) : DW'($urandom);
  always @(posedge clk) rd_data_b <= rd_en_b ? DW'(rd_addr_b) : DW'($urandom);

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [33:0] exp_q0[$];
  logic [33:0] exp_q1[$];
  logic [15:0] addr_q0[$];
  logic [15:0] addr_q1[$];
  int hs_cnt[2];
  int rd_cnt[2];
  int done_cnt[2];
  int rmode[2];
  bit stall_m[2];
  logic [33:0] prev_m[2];

  typedef struct {
    int   cyc;
    logic busy;
    logic valid;
    logic done;
    logic last;
    logic rd;
  } tim_t;
  tim_t tim[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference: walk the padded raster and list every element and every read.
  task automatic model_frame(input int w, input logic [15:0] base);
    int s, p, o;
    bit ins;
    logic [15:0] a;
    logic [33:0] e;
    s = (w == 0) ? SA : SB;
    p = (w == 0) ? PA : PB;
    o = s + 2 * p;
    for (int r = 0; r < o; r++) begin
      for (int c = 0; c < o; c++) begin
        ins = (r >= p) && (r < p + s) && (c >= p) && (c < p + s);
        a = 16'(int'(base) + (r - p) * s + (c - p));
        e = {(ins ? {16'h0, a} : 32'h0), (c == o - 1), (r == o - 1) && (c == o - 1)};
        if (w == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        if (ins) begin
          if (w == 0) addr_q0.push_back(a); else addr_q1.push_back(a);
        end
      end
    end
  endtask

  task automatic mon_step(input int w, input logic rst, input logic valid, input logic ready,
                          input logic rden, input logic dn, input logic [33:0] cur,
                          input logic [15:0] addr);
    logic [33:0] e;
    logic [15:0] ea;
    bool_empty: begin end
    if (rst) begin
      stall_m[w] = 1'b0;
      return;
    end
    if (stall_m[w]) begin
      check("stall_valid", valid, 1);
      check("stall_payload", cur, prev_m[w]);
    end
    if (valid && ready) begin
      hs_cnt[w]++;
      if ((w == 0 && exp_q0.size() == 0) || (w == 1 && exp_q1.size() == 0)) begin
        total++; bad++;
        $display("FAIL extra_elem dut%0d: got %0h required none", w, cur);
      end else begin
        if (w == 0) e = exp_q0.pop_front(); else e = exp_q1.pop_front();
        check("elem", cur, e);
      end
    end
    if (rden) begin
      rd_cnt[w]++;
      if ((w == 0 && addr_q0.size() == 0) || (w == 1 && addr_q1.size() == 0)) begin
        total++; bad++;
        $display("FAIL extra_read dut%0d: got %0h required none", w, addr);
      end else begin
        if (w == 0) ea = addr_q0.pop_front(); else ea = addr_q1.pop_front();
        check("rd_addr", addr, ea);
      end
    end
    if (dn) done_cnt[w]++;
    stall_m[w] = valid && !ready;
    prev_m[w]  = cur;
  endtask

  initial forever begin
    @(negedge clk);
    mon_step(0, rst_a, out_valid_a, out_ready_a, rd_en_a, done_a, {out_data_a, orl_a, ol_a}, rd_addr_a);
  end

  initial forever begin
    @(negedge clk);
    mon_step(1, rst_b, out_valid_b, out_ready_b, rd_en_b, done_b, {out_data_b, orl_b, ol_b}, rd_addr_b);
  end

  // ---------------- drivers ----------------
  // out_ready modes: 0 always 1, 1 pattern 1,0,0,1, 2 random, 3 always 0.
  initial begin
    int ph;
    logic v;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int w = 0; w < 2; w++) begin
        case (rmode[w])
          0:       v = 1'b1;
          1:       v = ((ph % 4) == 0) || ((ph % 4) == 3);
          2:       v = 1'($urandom_range(0, 1));
          default: v = 1'b0;
        endcase
        if (w == 0) out_ready_a = v; else out_ready_b = v;
      end
      ph++;
    end
  end

  task automatic set_start(input int w, input logic v, input logic [15:0] base);
    if (w == 0) begin start_a = v; base_a = base; end
    else        begin start_b = v; base_b = base; end
  endtask

  task automatic check_idle(input int w, input string tag);
    if (w == 0) begin
      check({tag, "_busy"}, busy_a, 0);
      check({tag, "_done"}, done_a, 0);
      check({tag, "_rd"}, {rd_en_a, rd_addr_a}, 0);
      check({tag, "_out"}, {out_valid_a, out_data_a, orl_a, ol_a}, 0);
      check({tag, "_state"}, st_a, 0);
    end else begin
      check({tag, "_busy"}, busy_b, 0);
      check({tag, "_done"}, done_b, 0);
      check({tag, "_rd"}, {rd_en_b, rd_addr_b}, 0);
      check({tag, "_out"}, {out_valid_b, out_data_b, orl_b, ol_b}, 0);
      check({tag, "_state"}, st_b, 0);
    end
  endtask

  // One full frame: optional timing table and optional stray start pulses.
  task automatic run_frame(input int w, input logic [15:0] base, input bit dup, input bit tchk);
    int s, o, h0, r0, d0;
    bit got;
    s = (w == 0) ? SA : SB;
    o = (w == 0) ? SA + 2 * PA : SB + 2 * PB;
    model_frame(w, base);
    h0 = hs_cnt[w]; r0 = rd_cnt[w]; d0 = done_cnt[w];
    @(posedge clk); #1;
    set_start(w, 1'b1, base);
    @(posedge clk); #1;
    set_start(w, 1'b0, base);
    got = 1'b0;
    for (int k = 1; k < 400 && !got; k++) begin
      @(negedge clk);
      if (tchk) begin
        for (int i = 0; i < 8; i++) begin
          if (tim[i].cyc == k) begin
            check($sformatf("t%0d_busy", k), busy_a, tim[i].busy);
            check($sformatf("t%0d_valid", k), out_valid_a, tim[i].valid);
            check($sformatf("t%0d_done", k), done_a, tim[i].done);
            check($sformatf("t%0d_last", k), ol_a, tim[i].last);
            check($sformatf("t%0d_rd_en", k), rd_en_a, tim[i].rd);
          end
        end
      end
      if (dup && k == 10) set_start(w, 1'b1, ~base);
      if (dup && k == 11) set_start(w, 1'b0, base);
      if ((w == 0) ? done_a : done_b) begin
        got = 1'b1;
        if (dup) set_start(w, 1'b1, ~base);
      end
    end
    check("frame_done_seen", got, 1);
    @(posedge clk); #1;
    set_start(w, 1'b0, base);
    repeat (4) @(negedge clk);
    check("frame_handshakes", hs_cnt[w] - h0, o * o);
    check("frame_reads", rd_cnt[w] - r0, s * s);
    check("frame_done_pulses", done_cnt[w] - d0, 1);
    check("frame_exp_left", (w == 0) ? exp_q0.size() : exp_q1.size(), 0);
    check("frame_busy_after", (w == 0) ? busy_a : busy_b, 0);
    if (w == 0) begin exp_q0.delete(); addr_q0.delete(); end
    else        begin exp_q1.delete(); addr_q1.delete(); end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n, d0;
    bit hit;
    rst_a = 1'b1; rst_b = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    base_a = '0; base_b = '0;
    out_ready_a = 1'b1; out_ready_b = 1'b1;
    rmode[0] = 0; rmode[1] = 0;
    hs_cnt = '{0, 0}; rd_cnt = '{0, 0}; done_cnt = '{0, 0};
    stall_m = '{0, 0};

    // Frame A timing with out_ready=1 (cycle 0 = start cycle).
    tim[0] = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tim[1] = '{2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tim[2] = '{7,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tim[3] = '{8,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tim[4] = '{9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tim[5] = '{10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tim[6] = '{26, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tim[7] = '{27, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle(0, "rst_a");
    check_idle(1, "rst_b");
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(posedge clk);

    // Basic frame, then out_ready 1,0,0,1, then stray starts.
    run_frame(0, 16'h0010, 1'b0, 1'b1);
    rmode[0] = 1;
    run_frame(0, 16'h0010, 1'b0, 1'b0);
    rmode[0] = 0;
    run_frame(0, 16'h0040, 1'b1, 1'b0);

    // Reset while the 7th element is stalled.
    model_frame(0, 16'h0020);
    d0 = done_cnt[0];
    @(posedge clk); #1;
    set_start(0, 1'b1, 16'h0020);
    @(posedge clk); #1;
    set_start(0, 1'b0, 16'h0020);
    n = 0; hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clk);
      if (out_valid_a && out_ready_a) n++;
      if (n == 6) hit = 1'b1;
    end
    check("rst_six_handshakes", hit, 1);
    rmode[0] = 3;
    @(negedge clk);
    check("rst_7th_valid", out_valid_a, 1);
    check("rst_7th_data", out_data_a, 32'h20);
    @(negedge clk);
    check("stall_no_issue", rd_en_a, 0);
    check("stall_7th_data", out_data_a, 32'h20);
    @(posedge clk); #1;
    rst_a = 1'b1;
    exp_q0.delete(); addr_q0.delete();
    @(posedge clk); #1;
    rst_a = 1'b0;
    @(negedge clk);
    check_idle(0, "midrst");
    repeat (3) @(negedge clk);
    check("midrst_no_done", done_cnt[0] - d0, 0);
    rmode[0] = 0;
    run_frame(0, 16'h0010, 1'b0, 1'b0);

    // Random readiness and bases on A.
    rmode[0] = 2;
    repeat (4) run_frame(0, 16'($urandom), 1'b0, 1'b0);

    // PAD=0 passthrough, address wrap, then random on B.
    rmode[1] = 0;
    run_frame(1, 16'h0100, 1'b0, 1'b0);
    run_frame(1, 16'hFFFE, 1'b0, 1'b0);
    rmode[1] = 2;
    repeat (4) run_frame(1, 16'($urandom), 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
